// File: rtl/crc_append_pkg.sv
// Shared constants and types for the serial CRC append stage.
//   - Packet type markers as seen on pkt_in.
//   - Packet bit sizes: header, token and data totals.
//   - CRC polynomials (implicit top term).
//   - FSM state enum and a helper returning the expected total length.
package crc_append_pkg;

    localparam logic [1:0] PKT_NONE   = 2'b00;
    localparam logic [1:0] PKT_TOKEN  = 2'b01;
    localparam logic [1:0] PKT_HSHAKE = 2'b10;
    localparam logic [1:0] PKT_DATA   = 2'b11;

    localparam int         HDR_BITS    = 16;
    localparam logic [6:0] HDR_LAST    = 7'(HDR_BITS - 1);
    localparam logic [6:0] TOKEN_BITS  = 7'd27;
    localparam logic [6:0] DATA_BITS   = 7'd80;
    localparam logic [6:0] HSHAKE_BITS = 7'd16;

    localparam logic [4:0]  CRC5_POLY  = 5'b00101;
    localparam logic [15:0] CRC16_POLY = 16'h8005;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY,
        ST_APPEND,
        ST_DONE
    } state_t;

    // Total packet length (header + payload) the encoder should deliver.
    function automatic logic [6:0] payload_end(input logic [1:0] typ);
        return (typ == PKT_DATA) ? DATA_BITS : TOKEN_BITS;
    endfunction

endpackage

// File: rtl/crc_append_if.sv
// Bus between the packet encoder, the CRC append stage and the bit stuffer.
//   pkt_in    : type marker pulse (00 none, 01 token, 10 handshake, 11 data)
//   endr      : encoder end marker
//   s_in      : serial input bit
//   s_out     : serial output bit
//   bit_valid : s_out carries a packet bit
//   sop/eop   : first/last bit of a packet
//   busy      : packet in progress
//   len_err   : one-cycle length error pulse
// master = encoder/stuffer side, slave = the CRC append stage.
interface crc_append_if;
    logic [1:0] pkt_in;
    logic       endr;
    logic       s_in;
    logic       s_out;
    logic       bit_valid;
    logic       sop;
    logic       eop;
    logic       busy;
    logic       len_err;

    modport master (
        output pkt_in, endr, s_in,
        input  s_out, bit_valid, sop, eop, busy, len_err
    );

    modport slave (
        input  pkt_in, endr, s_in,
        output s_out, bit_valid, sop, eop, busy, len_err
    );
endinterface

// File: rtl/crc_append_crc_serial.sv
// Serial MSB-first CRC register.
//   clk, rst_n : clock, synchronous active-low reset (register to all ones)
//   init       : reload all ones
//   en         : advance one bit: fb = d ^ crc[MSB]; crc = (crc << 1) ^ (fb ? POLY : 0)
//   d          : serial data bit
//   crc        : current register value
// Feeding d = crc[MSB] makes fb zero, so the register shifts left with no
// feedback; the append phase uses this to walk the CRC out MSB first.
module crc_append_crc_serial #(
    parameter int           W    = 5,
    parameter logic [W-1:0] POLY = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic         en,
    input  logic         d,
    output logic [W-1:0] crc
);
    logic [W-1:0] crc_q, crc_d;
    logic         fb;

    assign fb = d ^ crc_q[W-1];

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = '1;
        end else if (en) begin
            crc_d = {crc_q[W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= '1;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;
endmodule

// File: rtl/crc_append.sv
// Serial CRC append stage between the packet encoder and the bit stuffer.
// Passes SYNC+PID through, runs CRC5 (token) or CRC16 (data) over the
// payload, then appends the complemented CRC MSB first with sop/eop framing.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : crc_append_if.slave (pkt_in/endr/s_in in; s_out/bit_valid/
//                sop/eop/busy/len_err out)
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for a pkt_in marker; CRC held at all ones
// ST_HDR    | passing SYNC+PID, bit count 0..15
// ST_BODY   | passing payload bits and updating the selected CRC
// ST_APPEND | shifting out ~CRC, MSB first; eop on the last bit
// ST_DONE   | waiting for the encoder to drop endr
module crc_append
    import crc_append_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    crc_append_if.slave     bus
);
    state_t      state_q, state_d;
    logic [1:0]  typ_q, typ_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [3:0]  app_q, app_d;
    logic        s_out_q, s_out_d;
    logic        valid_q, valid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic        len_err_q, len_err_d;

    logic [4:0]  crc5;
    logic [15:0] crc16;
    logic [6:0]  cnt_inc;
    logic [6:0]  total;
    logic [3:0]  app_load;
    logic        crc_msb;
    logic        in_append;
    logic        body_take;
    logic        crc_en;

    assign cnt_inc   = (cnt_q == 7'd127) ? cnt_q : cnt_q + 7'd1;
    assign total     = payload_end(typ_q);
    assign app_load  = (typ_q == PKT_DATA) ? 4'd15 : 4'd4;
    assign crc_msb   = (typ_q == PKT_DATA) ? crc16[15] : crc5[4];
    assign in_append = (state_q == ST_APPEND);
    assign body_take = (state_q == ST_BODY) && !bus.endr && (cnt_q != total);
    assign crc_en    = body_take || in_append;

    crc_append_crc_serial #(.W(5), .POLY(CRC5_POLY)) u_crc5 (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (state_q == ST_IDLE),
        .en    (crc_en && (typ_q == PKT_TOKEN)),
        .d     (in_append ? crc5[4] : bus.s_in),
        .crc   (crc5)
    );

    crc_append_crc_serial #(.W(16), .POLY(CRC16_POLY)) u_crc16 (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (state_q == ST_IDLE),
        .en    (crc_en && (typ_q == PKT_DATA)),
        .d     (in_append ? crc16[15] : bus.s_in),
        .crc   (crc16)
    );

    always_comb begin
        state_d   = state_q;
        typ_d     = typ_q;
        cnt_d     = cnt_q;
        app_d     = app_q;
        s_out_d   = 1'b0;
        valid_d   = 1'b0;
        sop_d     = 1'b0;
        eop_d     = 1'b0;
        len_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.pkt_in != PKT_NONE) begin
                    typ_d   = bus.pkt_in;
                    cnt_d   = '0;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (bus.endr) begin
                    // Truncated header: nothing more to consume, close the packet.
                    len_err_d = 1'b1;
                    if (typ_q == PKT_HSHAKE) begin
                        state_d = ST_DONE;
                    end else begin
                        app_d   = app_load;
                        state_d = ST_APPEND;
                    end
                end else begin
                    s_out_d = bus.s_in;
                    valid_d = 1'b1;
                    sop_d   = (cnt_q == '0);
                    cnt_d   = cnt_inc;
                    if (cnt_q == HDR_LAST) begin
                        if (typ_q == PKT_HSHAKE) begin
                            eop_d   = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_BODY;
                        end
                    end
                end
            end
            ST_BODY: begin
                if (bus.endr || (cnt_q == total)) begin
                    // Error if endr is early, or if it has not arrived by the full length.
                    len_err_d = bus.endr ? (cnt_q != total) : 1'b1;
                    app_d     = app_load;
                    state_d   = ST_APPEND;
                end else begin
                    s_out_d = bus.s_in;
                    valid_d = 1'b1;
                    cnt_d   = cnt_inc;
                end
            end
            ST_APPEND: begin
                s_out_d = ~crc_msb;
                valid_d = 1'b1;
                if (app_q == '0) begin
                    eop_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    app_d = app_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (!bus.endr) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            typ_q     <= PKT_NONE;
            cnt_q     <= '0;
            app_q     <= '0;
            s_out_q   <= 1'b0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            typ_q     <= typ_d;
            cnt_q     <= cnt_d;
            app_q     <= app_d;
            s_out_q   <= s_out_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            len_err_q <= len_err_d;
        end
    end

    assign bus.s_out     = s_out_q;
    assign bus.bit_valid = valid_q;
    assign bus.sop       = sop_q;
    assign bus.eop       = eop_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.len_err   = len_err_q;
endmodule

// File: tb/tb_crc_append.sv
// Bench for crc_append: stimulus pushes expected output bits into a queue,
// a negedge monitor pops and compares whenever bit_valid is high, and also
// checks the CRC residue of each completed token/data packet.
module tb_crc_append;
    import crc_append_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crc_append_if bus ();

    crc_append dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       b;
        logic       sop;
        logic       eop;
        logic [1:0] typ;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          failures = 0;
    int          err_pulses = 0;
    int          mon_idx = 0;
    logic [15:0] r16 = '1;
    logic [15:0] r5 = 16'h001f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input int w,
                                             input logic [15:0] poly, input logic b);
        logic [16:0] one;
        logic [15:0] mask;
        logic        fb;
        one  = 17'd1;
        mask = 16'((one << w) - 17'd1);
        fb   = b ^ c[w-1];
        return ((c << 1) & mask) ^ (fb ? poly : 16'h0);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (bus.len_err === 1'b1) err_pulses++;
        if (bus.bit_valid === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_bit: got bit %0b with empty queue, expected no bit", bus.s_out);
            end else begin
                e = expq.pop_front();
                check("out_bit_sop_eop", {29'd0, bus.s_out, bus.sop, bus.eop}, {29'd0, e.b, e.sop, e.eop});
                if (bus.sop) begin
                    mon_idx = 0;
                    r16 = '1;
                    r5  = 16'h001f;
                end
                if (mon_idx >= HDR_BITS) begin
                    r16 = crc_step(r16, 16, CRC16_POLY, bus.s_out);
                    r5  = crc_step(r5, 5, {11'd0, CRC5_POLY}, bus.s_out);
                end
                mon_idx++;
                if (bus.eop && e.typ == PKT_TOKEN) check("residue5", {16'd0, r5}, 32'h0000_000c);
                if (bus.eop && e.typ == PKT_DATA)  check("residue16", {16'd0, r16}, 32'h0000_800d);
            end
        end
    end

    task automatic send(input logic [1:0] typ, input int n, input logic [127:0] bits,
                        input int hold, input bit pulse_chk);
        int          total;
        int          consumed;
        int          w;
        int          e0;
        int          t;
        logic [15:0] poly;
        logic [15:0] c;
        exp_t        e;
        total    = (typ == PKT_DATA) ? 80 : ((typ == PKT_TOKEN) ? 27 : 16);
        consumed = (typ == PKT_HSHAKE) ? 16 : ((n < total) ? n : total);
        w        = (typ == PKT_DATA) ? 16 : 5;
        poly     = (typ == PKT_DATA) ? CRC16_POLY : {11'd0, CRC5_POLY};
        e0       = err_pulses;
        for (int i = 0; i < consumed; i++) begin
            e.b = bits[i]; e.sop = (i == 0); e.eop = (typ == PKT_HSHAKE && i == 15); e.typ = typ;
            expq.push_back(e);
        end
        if (typ != PKT_HSHAKE) begin
            c = (w == 16) ? 16'hffff : 16'h001f;
            for (int i = 16; i < consumed; i++) c = crc_step(c, w, poly, bits[i]);
            for (int k = w - 1; k >= 0; k--) begin
                e.b = ~c[k]; e.sop = 1'b0; e.eop = (k == 0); e.typ = typ;
                expq.push_back(e);
            end
        end
        bus.pkt_in = typ;
        tick();
        bus.pkt_in = PKT_NONE;
        for (int i = 0; i < n; i++) begin
            bus.s_in = bits[i];
            tick();
        end
        bus.s_in = 1'b0;
        bus.endr = 1'b1;
        for (int j = 0; j < hold; j++) begin
            bus.pkt_in = (pulse_chk && (j % 3 == 1)) ? PKT_TOKEN : PKT_NONE;
            tick();
            if (pulse_chk) check("busy_while_endr", {31'd0, bus.busy}, 32'd1);
        end
        bus.pkt_in = PKT_NONE;
        bus.endr   = 1'b0;
        t = 0;
        while (bus.busy && t < 200) begin
            tick();
            t++;
        end
        if (bus.busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: got busy=1 after %0d cycles, expected busy=0", t);
        end
        check("len_err_count", err_pulses - e0,
              ((typ != PKT_HSHAKE) && (n != total)) ? 32'd1 : 32'd0);
    endtask

    function automatic logic [127:0] with_hdr(input logic [15:0] hdr);
        logic [127:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) b[i] = hdr[15-i];
        return b;
    endfunction

    initial begin
        logic [127:0] b;
        bus.pkt_in = PKT_NONE;
        bus.endr   = 1'b0;
        bus.s_in   = 1'b0;
        rst_n      = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {26'd0, bus.s_out, bus.bit_valid, bus.sop, bus.eop, bus.busy, bus.len_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Handshake: 16 bits echoed, eop on bit 15, no append
        send(PKT_HSHAKE, 16, with_hdr(16'h80D2), 3, 1'b0);

        // Token, 11 zero payload bits: appended 0,1,0,0,0
        send(PKT_TOKEN, 27, with_hdr(16'h80E1), 4, 1'b0);

        // Data, 100 random payloads
        for (int s = 0; s < 100; s++) begin
            b = with_hdr(16'h80C3);
            for (int i = 16; i < 80; i++) b[i] = 1'($urandom_range(0, 1));
            send(PKT_DATA, 80, b, 2, 1'b0);
        end

        // Token with endr at count 20 (short), and with endr late (long)
        b = with_hdr(16'h8069);
        b[16] = 1'b1; b[18] = 1'b1; b[19] = 1'b1;
        send(PKT_TOKEN, 20, b, 8, 1'b0);
        b[26] = 1'b1; b[28] = 1'b1;
        send(PKT_TOKEN, 30, b, 8, 1'b0);

        // endr held past eop with pkt_in pulses, then back-to-back token
        b = with_hdr(16'h80E1);
        b[17] = 1'b1; b[21] = 1'b1; b[25] = 1'b1;
        send(PKT_TOKEN, 27, b, 16, 1'b1);
        b[16] = 1'b1;
        send(PKT_TOKEN, 27, b, 2, 1'b0);

        // Reset in the middle of a data body
        b = with_hdr(16'h80C3);
        for (int i = 16; i < 30; i++) b[i] = i[0];
        bus.pkt_in = PKT_DATA;
        tick();
        bus.pkt_in = PKT_NONE;
        for (int i = 0; i < 30; i++) begin
            exp_t e;
            e.b = b[i]; e.sop = (i == 0); e.eop = 1'b0; e.typ = PKT_DATA;
            expq.push_back(e);
        end
        for (int i = 0; i < 30; i++) begin
            bus.s_in = b[i];
            tick();
        end
        rst_n = 1'b0;
        tick();
        check("mid_reset_outputs", {26'd0, bus.s_out, bus.bit_valid, bus.sop, bus.eop, bus.busy, bus.len_err}, 32'd0);
        rst_n    = 1'b1;
        bus.s_in = 1'b0;
        tick();
        send(PKT_HSHAKE, 16, with_hdr(16'h805A), 2, 1'b0);

        repeat (4) tick();
        check("queue_empty", expq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
